// File: rtl/lcd_ctrl.sv
// HD44780-style write sequencer: setup, EN pulse, hold, execution wait.
// Optional power-up init sequence when LCD_INIT_EN is defined.
module lcd_ctrl #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000,
    parameter int T_POWERUP   = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    input  logic        i_lcd_vld,
    output logic        o_lcd_rdy,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy
);

    localparam int M0 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int M1 = (M0 > T_HOLD) ? M0 : T_HOLD;
    localparam int M2 = (M1 > T_EXEC) ? M1 : T_EXEC;
    localparam int M3 = (M2 > T_EXEC_LONG) ? M2 : T_EXEC_LONG;
    localparam int MAXP = (M3 > T_POWERUP) ? M3 : T_POWERUP;
    localparam int CW = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PWRUP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          on_q, on_d;
    logic          long_q, long_d;
    logic          en_q, rdy_q, busy_q;
    logic          unused_bits;

    assign unused_bits = ^{i_lcd_word[30:10], i_lcd_word[8]};

    // Clear and home (RS=0, DATA[7:2]==0) need the long execution wait.
    function automatic logic is_long(input logic rs, input logic [7:0] d);
        return !rs && (d[7:2] == 6'd0);
    endfunction

`ifdef LCD_INIT_EN
    localparam state_t        RST_STATE = S_PWRUP;
    localparam logic [CW-1:0] RST_CNT   = CW'(T_POWERUP - 1);
    localparam logic          RST_RDY   = 1'b0;

    logic [1:0] idx_q, idx_d;
    logic       init_q, init_d;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        unique case (i)
            2'd0: return 8'h38;
            2'd1: return 8'h0C;
            2'd2: return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`else
    localparam state_t        RST_STATE = S_IDLE;
    localparam logic [CW-1:0] RST_CNT   = '0;
    localparam logic          RST_RDY   = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        on_d    = on_q;
        long_d  = long_q;
`ifdef LCD_INIT_EN
        idx_d   = idx_q;
        init_d  = init_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_lcd_vld) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                    rs_d    = i_lcd_word[9];
                    data_d  = i_lcd_word[7:0];
                    on_d    = i_lcd_word[31];
                    long_d  = is_long(i_lcd_word[9], i_lcd_word[7:0]);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CW'(T_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = long_q ? CW'(T_EXEC_LONG - 1)
                                     : CW'(T_EXEC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                    if (init_q && idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_SETUP;
                        cnt_d   = CW'(T_SETUP - 1);
                        data_d  = init_byte(idx_q + 2'd1);
                        long_d  = is_long(1'b0, init_byte(idx_q + 2'd1));
                    end else begin
                        init_d  = 1'b0;
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PWRUP: begin
`ifdef LCD_INIT_EN
                on_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                    rs_d    = 1'b0;
                    data_d  = init_byte(2'd0);
                    long_d  = is_long(1'b0, init_byte(2'd0));
                    idx_d   = 2'd0;
                    init_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            on_q    <= 1'b0;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
            rdy_q   <= RST_RDY;
            busy_q  <= !RST_RDY;
`ifdef LCD_INIT_EN
            idx_q   <= 2'd0;
            init_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            on_q    <= on_d;
            long_q  <= long_d;
            en_q    <= (state_d == S_PULSE);
            rdy_q   <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
`ifdef LCD_INIT_EN
            idx_q   <= idx_d;
            init_q  <= init_d;
`endif
        end
    end

    assign o_lcd_rdy  = rdy_q;
    assign o_busy     = busy_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_lcd_on   = on_q;

endmodule
